// File: rtl/cpu_datapath.sv
// 8-bit 6502-style datapath: register file, PC, temp latch, D latch, P and ALU, all steered by microcode.
// Optional BCD arithmetic for ops 2/3 when P.D is set is enabled with DECIMAL_MODE_EN.
module cpu_datapath #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  RESET_SP = 8'hFF
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [15:0] address,
  input  logic        th_in_en,
  input  logic        tl_in_en,
  input  logic        th_out_en,
  input  logic        tl_out_en,
  input  logic [7:0]  p_in_en,
  input  logic        p_out_en,
  input  logic        p_sel,
  input  logic        reg_write_en,
  input  logic [1:0]  reg_read_addr_a,
  input  logic [1:0]  reg_read_addr_b,
  input  logic [1:0]  reg_write_addr,
  input  logic        reg_a_en,
  input  logic        pch_in_en,
  input  logic        pcl_in_en,
  input  logic        pch_out_en,
  input  logic        pcl_out_en,
  input  logic        pc_inc_en,
  input  logic        pc_sel,
  input  logic        d_in_en,
  input  logic        d_out_sel,
  input  logic [1:0]  ah_sel,
  input  logic        al_sel,
  input  logic [3:0]  alu_op,
  input  logic        c_temp_en,
  input  logic        carry_sel
);

  // P bits the ALU may write when p_sel selects flags (N, V, Z, C)
  localparam logic [7:0] ALU_FLAG_MASK = 8'b1100_0011;

  logic [3:0][7:0] rf_q, rf_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  th_q, th_d, tl_q, tl_d, d_q, d_d, p_q, p_d;
  logic        c_temp_q, c_temp_d;

  logic [7:0]  op_a_s, op_b_s, alu_res_s, result_bus_s, alu_flags_s, ah_s, al_s;
  logic        cin_s, alu_c_s, alu_v_s, alu_n_s, alu_z_s, dec_active_s;
  logic [8:0]  sum_s;
  logic [15:0] pc_base_s, pc_next_s;
  logic [7:0]  dec_res_s;
  logic        dec_c_s;

`ifdef DECIMAL_MODE_EN
  logic [4:0] dlo_s, dhi_s;
  logic       lo_c_s, hi_c_s;

  // BCD adjust of the add (op 2) or subtract (op 3) one nibble at a time
  always_comb begin
    dlo_s  = 5'h00;
    dhi_s  = 5'h00;
    lo_c_s = 1'b0;
    hi_c_s = 1'b0;
    if (alu_op == 4'h3) begin
      dlo_s  = {1'b0, op_a_s[3:0]} - {1'b0, op_b_s[3:0]} - {4'h0, ~cin_s};
      lo_c_s = dlo_s[4];
      if (lo_c_s) dlo_s = dlo_s - 5'd6; else dlo_s = dlo_s;
      dhi_s  = {1'b0, op_a_s[7:4]} - {1'b0, op_b_s[7:4]} - {4'h0, lo_c_s};
      hi_c_s = dhi_s[4];
      if (hi_c_s) dhi_s = dhi_s - 5'd6; else dhi_s = dhi_s;
      dec_c_s = ~hi_c_s;
    end else begin
      dlo_s  = {1'b0, op_a_s[3:0]} + {1'b0, op_b_s[3:0]} + {4'h0, cin_s};
      lo_c_s = (dlo_s > 5'd9);
      if (lo_c_s) dlo_s = dlo_s + 5'd6; else dlo_s = dlo_s;
      dhi_s  = {1'b0, op_a_s[7:4]} + {1'b0, op_b_s[7:4]} + {4'h0, lo_c_s};
      hi_c_s = (dhi_s > 5'd9);
      if (hi_c_s) dhi_s = dhi_s + 5'd6; else dhi_s = dhi_s;
      dec_c_s = hi_c_s;
    end
    dec_res_s = {dhi_s[3:0], dlo_s[3:0]};
  end
  assign dec_active_s = p_q[3];
`else
  assign dec_res_s    = 8'h00;
  assign dec_c_s      = 1'b0;
  assign dec_active_s = 1'b0;
`endif

  assign op_a_s = reg_a_en ? rf_q[reg_read_addr_a] : d_q;
  assign op_b_s = rf_q[reg_read_addr_b];
  assign cin_s  = carry_sel ? c_temp_q : p_q[0];

  // ALU datapath and flag generation
  always_comb begin
    alu_res_s = 8'h00;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    sum_s     = 9'h000;
    case (alu_op)
      4'h0: alu_res_s = op_a_s;
      4'h1: alu_res_s = op_b_s;
      4'h2: begin
        sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s} + {8'h00, cin_s};
        alu_res_s = sum_s[7:0];
        alu_c_s   = sum_s[8];
        alu_v_s   = (op_a_s[7] == op_b_s[7]) && (sum_s[7] != op_a_s[7]);
        if (dec_active_s) begin
          alu_res_s = dec_res_s;
          alu_c_s   = dec_c_s;
        end else begin
          alu_res_s = sum_s[7:0];
        end
      end
      4'h3: begin
        sum_s     = {1'b0, op_a_s} + {1'b0, ~op_b_s} + {8'h00, cin_s};
        alu_res_s = sum_s[7:0];
        alu_c_s   = sum_s[8];
        alu_v_s   = (op_a_s[7] != op_b_s[7]) && (sum_s[7] != op_a_s[7]);
        if (dec_active_s) begin
          alu_res_s = dec_res_s;
          alu_c_s   = dec_c_s;
        end else begin
          alu_res_s = sum_s[7:0];
        end
      end
      4'h4: alu_res_s = op_a_s & op_b_s;
      4'h5: alu_res_s = op_a_s | op_b_s;
      4'h6: alu_res_s = op_a_s ^ op_b_s;
      4'h7: alu_res_s = op_a_s + 8'h01;
      4'h8: alu_res_s = op_a_s - 8'h01;
      4'h9: begin alu_res_s = {op_a_s[6:0], 1'b0};  alu_c_s = op_a_s[7]; end
      4'hA: begin alu_res_s = {1'b0, op_a_s[7:1]};  alu_c_s = op_a_s[0]; end
      4'hB: begin alu_res_s = {op_a_s[6:0], cin_s}; alu_c_s = op_a_s[7]; end
      4'hC: begin alu_res_s = {cin_s, op_a_s[7:1]}; alu_c_s = op_a_s[0]; end
      4'hD: begin
        sum_s     = {1'b0, op_a_s} + {1'b0, ~op_b_s} + 9'h001;
        alu_res_s = sum_s[7:0];
        alu_c_s   = sum_s[8];
      end
      4'hE: begin alu_res_s = op_a_s & op_b_s; alu_v_s = op_a_s[6]; end
      default: alu_res_s = 8'h00;
    endcase
    alu_z_s = (alu_res_s == 8'h00);
    alu_n_s = (alu_op == 4'hE) ? op_a_s[7] : alu_res_s[7];
  end

  assign alu_flags_s = {alu_n_s, alu_v_s, 1'b1, 1'b0, 1'b0, 1'b0, alu_z_s, alu_c_s};

  // Result bus priority mux and output drivers
  always_comb begin
    if (pch_out_en)      result_bus_s = pc_q[15:8];
    else if (pcl_out_en) result_bus_s = pc_q[7:0];
    else if (th_out_en)  result_bus_s = th_q;
    else if (tl_out_en)  result_bus_s = tl_q;
    else if (p_out_en)   result_bus_s = p_q;
    else                 result_bus_s = alu_res_s;
    case (ah_sel)
      2'b00:   ah_s = pc_q[15:8];
      2'b01:   ah_s = th_q;
      2'b10:   ah_s = 8'h00;
      2'b11:   ah_s = 8'h01;
      default: ah_s = 8'h00;
    endcase
    al_s = al_sel ? tl_q : pc_q[7:0];
  end

  assign data_out = d_out_sel ? d_q : result_bus_s;
  assign address  = {ah_s, al_s};

  assign pc_base_s = pc_sel ? {th_q, tl_q} : pc_q;
  assign pc_next_s = pc_base_s + {15'h0000, pc_inc_en};

  // Next-state for every register
  always_comb begin
    rf_d = rf_q;
    if (reg_write_en) rf_d[reg_write_addr] = alu_res_s; else rf_d = rf_q;
    pc_d     = {pch_in_en ? pc_next_s[15:8] : pc_q[15:8], pcl_in_en ? pc_next_s[7:0] : pc_q[7:0]};
    th_d     = th_in_en  ? alu_res_s : th_q;
    tl_d     = tl_in_en  ? alu_res_s : tl_q;
    d_d      = d_in_en   ? data_in   : d_q;
    c_temp_d = c_temp_en ? alu_c_s   : c_temp_q;
    p_d      = p_q;
    for (int i = 0; i < 8; i++) begin
      if (p_in_en[i] && p_sel)                    p_d[i] = d_q[i];
      else if (p_in_en[i] && ALU_FLAG_MASK[i])    p_d[i] = alu_flags_s[i];
      else                                        p_d[i] = p_q[i];
    end
    p_d[5] = 1'b1;
  end

  // State registers
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      rf_q     <= {RESET_SP, 8'h00, 8'h00, 8'h00};
      pc_q     <= RESET_PC;
      th_q     <= 8'h00;
      tl_q     <= 8'h00;
      d_q      <= 8'h00;
      c_temp_q <= 1'b0;
      p_q      <= 8'h24;
    end else begin
      rf_q     <= rf_d;
      pc_q     <= pc_d;
      th_q     <= th_d;
      tl_q     <= tl_d;
      d_q      <= d_d;
      c_temp_q <= c_temp_d;
      p_q      <= p_d;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath.
module tb_cpu_datapath;

  logic        ph1, reset;
  logic [7:0]  data_in, data_out;
  logic [15:0] address;
  logic        th_in_en, tl_in_en, th_out_en, tl_out_en;
  logic [7:0]  p_in_en;
  logic        p_out_en, p_sel, reg_write_en;
  logic [1:0]  reg_read_addr_a, reg_read_addr_b, reg_write_addr;
  logic        reg_a_en, pch_in_en, pcl_in_en, pch_out_en, pcl_out_en;
  logic        pc_inc_en, pc_sel, d_in_en, d_out_sel;
  logic [1:0]  ah_sel;
  logic        al_sel;
  logic [3:0]  alu_op;
  logic        c_temp_en, carry_sel;

  int checks = 0;
  int errors = 0;

  cpu_datapath dut (
    .ph1(ph1), .reset(reset), .data_in(data_in), .data_out(data_out), .address(address),
    .th_in_en(th_in_en), .tl_in_en(tl_in_en), .th_out_en(th_out_en), .tl_out_en(tl_out_en),
    .p_in_en(p_in_en), .p_out_en(p_out_en), .p_sel(p_sel), .reg_write_en(reg_write_en),
    .reg_read_addr_a(reg_read_addr_a), .reg_read_addr_b(reg_read_addr_b),
    .reg_write_addr(reg_write_addr), .reg_a_en(reg_a_en),
    .pch_in_en(pch_in_en), .pcl_in_en(pcl_in_en), .pch_out_en(pch_out_en), .pcl_out_en(pcl_out_en),
    .pc_inc_en(pc_inc_en), .pc_sel(pc_sel), .d_in_en(d_in_en), .d_out_sel(d_out_sel),
    .ah_sel(ah_sel), .al_sel(al_sel), .alu_op(alu_op), .c_temp_en(c_temp_en), .carry_sel(carry_sel)
  );

  initial begin
    ph1 = 1'b0;
    forever #5 ph1 = ~ph1;
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Route D latch into a destination: load data_in, then pass D through the ALU
  task automatic load_d(input logic [7:0] v);
    data_in = v; d_in_en = 1'b1; tick(); d_in_en = 1'b0;
    alu_op = 4'h0; reg_a_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; data_in = 8'h00;
    th_in_en = 1'b0; tl_in_en = 1'b0; th_out_en = 1'b0; tl_out_en = 1'b0;
    p_in_en = 8'h00; p_out_en = 1'b0; p_sel = 1'b0; reg_write_en = 1'b0;
    reg_read_addr_a = 2'b00; reg_read_addr_b = 2'b00; reg_write_addr = 2'b00; reg_a_en = 1'b0;
    pch_in_en = 1'b0; pcl_in_en = 1'b0; pch_out_en = 1'b0; pcl_out_en = 1'b0;
    pc_inc_en = 1'b0; pc_sel = 1'b0; d_in_en = 1'b0; d_out_sel = 1'b0;
    ah_sel = 2'b00; al_sel = 1'b0; alu_op = 4'h0; c_temp_en = 1'b0; carry_sel = 1'b0;

    repeat (10) @(posedge ph1);
    #1;
    chk("rst_address", address, 16'h0000);
    p_out_en = 1'b1; #1;
    chk("rst_p", {8'h00, data_out}, 16'h0024);
    p_out_en = 1'b0; alu_op = 4'h1; reg_read_addr_b = 2'b11; #1;
    chk("rst_s", {8'h00, data_out}, 16'h00FF);
    reset = 1'b1;

    // PC increments five times
    alu_op = 4'h0; reg_read_addr_b = 2'b00;
    pch_in_en = 1'b1; pcl_in_en = 1'b1; pc_inc_en = 1'b1;
    repeat (5) tick();
    pch_in_en = 1'b0; pcl_in_en = 1'b0; pc_inc_en = 1'b0; #1;
    chk("pc_5_addr", address, 16'h0005);
    pcl_out_en = 1'b1; #1;
    chk("pcl_out", {8'h00, data_out}, 16'h0005);
    pch_out_en = 1'b1; #1;
    chk("pch_out_prio", {8'h00, data_out}, 16'h0000);
    pch_out_en = 1'b0; pcl_out_en = 1'b0;

    // X <- 01 through D latch
    load_d(8'h01);
    reg_write_addr = 2'b01; reg_write_en = 1'b1; tick(); reg_write_en = 1'b0;
    alu_op = 4'h1;
    reg_read_addr_b = 2'b01; #1; chk("x_written", {8'h00, data_out}, 16'h0001);
    reg_read_addr_b = 2'b00; #1; chk("a_unchanged", {8'h00, data_out}, 16'h0000);
    reg_read_addr_b = 2'b10; #1; chk("y_unchanged", {8'h00, data_out}, 16'h0000);

    // A <- 7F
    load_d(8'h7F);
    reg_write_addr = 2'b00; reg_write_en = 1'b1; tick(); reg_write_en = 1'b0;

    // ALU with A=7F, X=01, P.C=0
    reg_a_en = 1'b1; reg_read_addr_a = 2'b00; reg_read_addr_b = 2'b01; carry_sel = 1'b0;
    alu_op = 4'h2; #1; chk("add_res", {8'h00, data_out}, 16'h0080);
    p_in_en = 8'hC3; tick(); p_in_en = 8'h00;
    p_out_en = 1'b1; #1; chk("add_flags_p", {8'h00, data_out}, 16'h00E4);
    p_out_en = 1'b0;
    alu_op = 4'h3; #1; chk("sbc_res", {8'h00, data_out}, 16'h007D);
    alu_op = 4'hD; #1; chk("cmp_res", {8'h00, data_out}, 16'h007E);
    alu_op = 4'h9; #1; chk("asl_res", {8'h00, data_out}, 16'h00FE);
    alu_op = 4'hE; #1; chk("bit_res", {8'h00, data_out}, 16'h0001);
    alu_op = 4'h7; #1; chk("inc_res", {8'h00, data_out}, 16'h0080);
    alu_op = 4'h8; #1; chk("dec_res", {8'h00, data_out}, 16'h007E);

    // C_TEMP captures LSR carry-out, then feeds ROL
    alu_op = 4'hA; c_temp_en = 1'b1; tick(); c_temp_en = 1'b0;
    alu_op = 4'hB; carry_sel = 1'b1; #1; chk("rol_ctemp", {8'h00, data_out}, 16'h00FF);
    carry_sel = 1'b0; #1; chk("rol_pc", {8'h00, data_out}, 16'h00FE);

    // P flag loading from ALU and from D latch
    alu_op = 4'hF; p_in_en = 8'h03; tick(); p_in_en = 8'h00;
    p_out_en = 1'b1; #1; chk("zero_flags_p", {8'h00, data_out}, 16'h00E6);
    p_sel = 1'b1; p_in_en = 8'hFF; tick(); p_in_en = 8'h00; #1;
    chk("p_from_d", {8'h00, data_out}, 16'h007F);
    p_sel = 1'b0; p_in_en = 8'hFF; tick(); p_in_en = 8'h00; #1;
    chk("p_alu_keeps_bdi", {8'h00, data_out}, 16'h003E);
    p_out_en = 1'b0;

    // Temp latch and jump via {TH,TL}+1
    load_d(8'h12); th_in_en = 1'b1; tick(); th_in_en = 1'b0;
    load_d(8'h34); tl_in_en = 1'b1; tick(); tl_in_en = 1'b0;
    ah_sel = 2'b01; al_sel = 1'b1; #1; chk("addr_thtl", address, 16'h1234);
    th_out_en = 1'b1; #1; chk("th_out", {8'h00, data_out}, 16'h0012);
    th_out_en = 1'b0; ah_sel = 2'b00; al_sel = 1'b0;
    pc_sel = 1'b1; pc_inc_en = 1'b1; pch_in_en = 1'b1; pcl_in_en = 1'b1; tick();
    pc_sel = 1'b0; pc_inc_en = 1'b0; pch_in_en = 1'b0; pcl_in_en = 1'b0; #1;
    chk("pc_jump_inc", address, 16'h1235);

    // PC wrap
    load_d(8'hFF); th_in_en = 1'b1; tl_in_en = 1'b1; tick(); th_in_en = 1'b0; tl_in_en = 1'b0;
    pc_sel = 1'b1; pch_in_en = 1'b1; pcl_in_en = 1'b1; tick(); pc_sel = 1'b0; #1;
    chk("pc_ffff", address, 16'hFFFF);
    pc_inc_en = 1'b1; tick(); #1;
    chk("pc_wrap", address, 16'h0000);
    pch_in_en = 1'b0; pc_inc_en = 1'b0;
    ah_sel = 2'b11; #1; chk("addr_page1", address, 16'h0100);
    ah_sel = 2'b00; pcl_in_en = 1'b1; pc_inc_en = 1'b1; tick();
    pcl_in_en = 1'b0; pc_inc_en = 1'b0; #1;
    chk("pcl_only_inc", address, 16'h0001);

    // Asynchronous reset mid-operation
    reset = 1'b0; #1;
    chk("rst2_address", address, 16'h0000);
    p_out_en = 1'b1; #1; chk("rst2_p", {8'h00, data_out}, 16'h0024);
    p_out_en = 1'b0; alu_op = 4'h1; reg_read_addr_b = 2'b00; #1;
    chk("rst2_a", {8'h00, data_out}, 16'h0000);
    reg_read_addr_b = 2'b01; #1; chk("rst2_x", {8'h00, data_out}, 16'h0000);
    reg_read_addr_b = 2'b11; #1; chk("rst2_s", {8'h00, data_out}, 16'h00FF);
    tl_out_en = 1'b1; #1; chk("rst2_tl", {8'h00, data_out}, 16'h0000);
    tl_out_en = 1'b0; d_out_sel = 1'b1; #1; chk("rst2_d", {8'h00, data_out}, 16'h0000);
    d_out_sel = 1'b0;
    tick(); reset = 1'b1; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
